// File: rtl/ecpri_pkg.sv
// Purpose : shared types and defaults for the eCPRI receive-side packet slot writer.
// Latency : n/a (types, constants and a helper function only).
// Backpr. : n/a.
// Contents: default widths, header lengths, writer FSM state enum, slot descriptor struct,
//           and a saturating add for the drop counter.
package ecpri_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH  = 16;
  localparam int ETH_HDR_LEN     = 14;
  localparam int ECPRI_HDR_LEN   = 4;
  localparam int DEF_MIN_PKT_LEN = ETH_HDR_LEN + ECPRI_HDR_LEN;

  // Descriptor fields are sized for the largest supported configuration
  // (up to 256 slots, up to 64K-beat slots); users narrow them with casts.
  localparam int DESC_SLOT_W = 8;
  localparam int DESC_LEN_W  = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DROP,
    ST_COMMIT
  } wr_state_e;

  typedef struct packed {
    logic [DESC_SLOT_W-1:0] slot;
    logic [DESC_LEN_W-1:0]  len;
  } slot_desc_t;

  // Up to two drops can be recorded in one cycle (a runt discard in COMMIT
  // plus a full-ring drop of the frame starting in that same cycle).
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/slot_desc_fifo.sv
// Purpose : in-order queue of committed slot descriptors awaiting the consumer.
// Latency : push/pop at edge n are visible on head/count in cycle n+1.
// Backpr. : none; push when full is ignored unless a pop happens in the same cycle.
// Ports   : clk/reset (sync, active-high); push_i + push_dat_i enqueue; pop_i dequeues
//           (ignored when empty); head_dat_o/head_vld_o = oldest entry; count_o = occupancy.
module slot_desc_fifo
  import ecpri_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  slot_desc_t       push_dat_i,
  input  logic             pop_i,
  output slot_desc_t       head_dat_o,
  output logic             head_vld_o,
  output logic [PTR_W:0]   count_o
);

  slot_desc_t           mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q, count_d;
  logic                 do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != (PTR_W+1)'(DEPTH)) || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_vld_o = (count_q != '0);
  assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

endmodule

// File: rtl/eth_pkt_slot_writer.sv
// Purpose : writes a byte-beat frame stream into fixed-size RAM slots and queues {slot,len} descriptors.
// Latency : beat at edge n drives RAM port in cycle n+1; descriptor visible 2 cycles after the last beat.
// Backpr. : none (in_ready=1 after reset); frames are dropped and counted when the ring is full or oversize.
// Ports   : in_data/in_valid/in_last/in_ready = beat stream; addr_0/data_0/we_0/cs_0/oe_0 = RAM port 0;
//           recv_pkt/rx_slot/rx_len = head descriptor, rx_done releases it; slots_used, drop_cnt = status.
// Macro   : ECPRI_MIN_LEN_CHECK_EN discards committing frames shorter than MIN_PKT_LEN.
module eth_pkt_slot_writer
  import ecpri_pkg::*;
#(
  parameter int  DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int  ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int  NUM_SLOTS       = 4,
  parameter int  SLOT_ADDR_WIDTH = 11,
  parameter int  MIN_PKT_LEN     = DEF_MIN_PKT_LEN,
  localparam int SLOT_IDX_W      = $clog2(NUM_SLOTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [ADDR_WIDTH-1:0]     addr_0,
  output logic [DATA_WIDTH-1:0]     data_0,
  output logic                      we_0,
  output logic                      cs_0,
  output logic                      oe_0,
  output logic                      recv_pkt,
  output logic [SLOT_IDX_W-1:0]     rx_slot,
  output logic [SLOT_ADDR_WIDTH:0]  rx_len,
  input  logic                      rx_done,
  output logic [SLOT_IDX_W:0]       slots_used,
  output logic [15:0]               drop_cnt
);

  localparam int LEN_W = SLOT_ADDR_WIDTH + 1;

  wr_state_e                  state_q, state_d;
  logic [SLOT_ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [SLOT_IDX_W-1:0]      wr_slot_q, wr_slot_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic                       we_q, we_d;
  logic [15:0]                drop_cnt_q, drop_cnt_d;
  logic                       ready_q;

  logic                       beat, full, runt, commit_push;
  logic [1:0]                 drop_inc;
  logic [LEN_W-1:0]           commit_len;
  logic [SLOT_IDX_W:0]        fifo_count;
  slot_desc_t                 push_desc, head_desc;

  assign beat       = in_valid && ready_q;
  // offset_q holds the offset of the last beat written, so length is one more.
  assign commit_len = {1'b0, offset_q} + LEN_W'(1);

`ifdef ECPRI_MIN_LEN_CHECK_EN
  assign runt = (state_q == ST_COMMIT) && (commit_len < LEN_W'(MIN_PKT_LEN));
`else
  assign runt = 1'b0;
`endif

  assign commit_push = (state_q == ST_COMMIT) && !runt;

  // A slot being committed this cycle is not yet in fifo_count but is already taken.
  assign full = (({1'b0, fifo_count} + (SLOT_IDX_W+2)'(commit_push)) == (SLOT_IDX_W+2)'(NUM_SLOTS));

  assign push_desc.slot = DESC_SLOT_W'(wr_slot_q);
  assign push_desc.len  = DESC_LEN_W'(commit_len);

  always_comb begin
    state_d   = state_q;
    offset_d  = offset_q;
    wr_slot_d = wr_slot_q;
    addr_d    = addr_q;
    data_d    = in_data;
    we_d      = 1'b0;
    drop_inc  = 2'd0;

    // COMMIT lasts one cycle; a runt discard leaves wr_slot in place for reuse.
    if (state_q == ST_COMMIT) begin
      state_d = ST_IDLE;
      if (commit_push) wr_slot_d = wr_slot_q + SLOT_IDX_W'(1);
      else             drop_inc  = drop_inc + 2'd1;
    end

    case (state_q)
      // A beat arriving during COMMIT starts the next frame in the slot after it.
      ST_IDLE, ST_COMMIT: begin
        if (beat) begin
          if (full) begin
            drop_inc = drop_inc + 2'd1;
            state_d  = in_last ? ST_IDLE : ST_DROP;
          end else begin
            we_d     = 1'b1;
            offset_d = '0;
            addr_d   = ADDR_WIDTH'({wr_slot_d, {SLOT_ADDR_WIDTH{1'b0}}});
            state_d  = in_last ? ST_COMMIT : ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (beat) begin
          if (&offset_q) begin
            // Would land past the end of the slot: abandon frame, keep wr_slot.
            drop_inc = drop_inc + 2'd1;
            state_d  = in_last ? ST_IDLE : ST_DROP;
          end else begin
            we_d     = 1'b1;
            offset_d = offset_q + SLOT_ADDR_WIDTH'(1);
            addr_d   = ADDR_WIDTH'({wr_slot_q, offset_d});
            state_d  = in_last ? ST_COMMIT : ST_WRITE;
          end
        end
      end
      ST_DROP: begin
        if (beat && in_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    drop_cnt_d = sat_add16(drop_cnt_q, drop_inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      offset_q   <= '0;
      wr_slot_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      drop_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      wr_slot_q  <= wr_slot_d;
      addr_q     <= addr_d;
      data_q     <= we_d ? data_d : '0;
      we_q       <= we_d;
      drop_cnt_q <= drop_cnt_d;
      ready_q    <= 1'b1;
    end
  end

  slot_desc_fifo #(
    .DEPTH (NUM_SLOTS)
  ) u_desc_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (commit_push),
    .push_dat_i (push_desc),
    .pop_i      (rx_done),
    .head_dat_o (head_desc),
    .head_vld_o (recv_pkt),
    .count_o    (fifo_count)
  );

  assign in_ready   = ready_q;
  assign addr_0     = addr_q;
  assign data_0     = data_q;
  assign we_0       = we_q;
  assign cs_0       = we_q;
  assign oe_0       = 1'b0;
  assign rx_slot    = SLOT_IDX_W'(head_desc.slot);
  assign rx_len     = LEN_W'(head_desc.len);
  assign slots_used = fifo_count;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_eth_pkt_slot_writer.sv
// Purpose : self-checking bench for eth_pkt_slot_writer against a frame-level reference model.
// Latency : n/a.
// Backpr. : n/a.
module tb_eth_pkt_slot_writer;

  localparam int NS   = 4;
  localparam int SW   = 11;
  localparam int SLOT = 1 << SW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [15:0] addr_0;
  logic [7:0]  data_0;
  logic        we_0, cs_0, oe_0;
  logic        recv_pkt;
  logic [1:0]  rx_slot;
  logic [11:0] rx_len;
  logic        rx_done = 1'b0;
  logic [2:0]  slots_used;
  logic [15:0] drop_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  eth_pkt_slot_writer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .addr_0(addr_0), .data_0(data_0), .we_0(we_0), .cs_0(cs_0),
    .oe_0(oe_0), .recv_pkt(recv_pkt), .rx_slot(rx_slot), .rx_len(rx_len), .rx_done(rx_done),
    .slots_used(slots_used), .drop_cnt(drop_cnt)
  );

  // External packet RAM driven by port 0.
  logic [7:0] ram [0:65535];
  always @(posedge clk) if (we_0 && cs_0) ram[addr_0] <= data_0;

  // Reference model: descriptor queue, write slot, drop count, expected RAM image.
  int         q_slot[$];
  int         q_len[$];
  int         m_wr_slot;
  int         m_drop;
  logic [7:0] exp_ram [0:NS*SLOT-1];
  logic [7:0] frm[$];

  function automatic bit is_runt(int len);
`ifdef ECPRI_MIN_LEN_CHECK_EN
    return len < 18;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_slot();
    return (q_slot.size() != 0) ? q_slot[0] : 0;
  endfunction

  function automatic int exp_len();
    return (q_len.size() != 0) ? q_len[0] : 0;
  endfunction

  function automatic int ram_diff();
    int n = 0;
    for (int i = 0; i < NS*SLOT; i++) if (ram[i] !== exp_ram[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    q_slot.delete();
    q_len.delete();
    m_wr_slot = 0;
    m_drop = 0;
  endtask

  task automatic model_drop();
    if (m_drop < 65535) m_drop++;
  endtask

  task automatic model_frame(int len, bit pop_on_commit);
    int pre = q_slot.size();
    if (pre == NS) model_drop();
    else begin
      int n = (len > SLOT) ? SLOT : len;
      for (int i = 0; i < n; i++) exp_ram[m_wr_slot*SLOT + i] = frm[i];
      if (len > SLOT || is_runt(len)) model_drop();
      else begin
        q_slot.push_back(m_wr_slot);
        q_len.push_back(len);
        m_wr_slot = (m_wr_slot + 1) % NS;
      end
    end
    if (pop_on_commit && pre > 0) begin
      void'(q_slot.pop_front());
      void'(q_len.pop_front());
    end
  endtask

  task automatic make_frame(int len, bit random_data);
    frm.delete();
    for (int i = 0; i < len; i++) frm.push_back(random_data ? 8'($urandom) : 8'(i));
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_beats(int n, bit end_with_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = frm[i];
      in_last  = end_with_last && (i == n - 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic send_frame(int len, bit pop_on_commit);
    model_frame(len, pop_on_commit);
    drive_beats(len, 1'b1);
    if (pop_on_commit) begin
      rx_done = 1'b1;
      @(posedge clk);
      #1;
      rx_done = 1'b0;
    end
  endtask

  task automatic do_rx_done();
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    if (q_slot.size() != 0) begin
      void'(q_slot.pop_front());
      void'(q_len.pop_front());
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0; rx_done = 1'b0;
    idle(2);
    reset = 1'b0;
    model_reset();
    idle(2);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_in_ready: got %0b want 0", in_ready);
    end
    vectors++;
    if ({recv_pkt, rx_slot, rx_len, slots_used, drop_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_status: got recv=%0b slot=%0d len=%0d used=%0d drop=%0d want all 0",
               recv_pkt, rx_slot, rx_len, slots_used, drop_cnt);
    end
    vectors++;
    if ({addr_0, data_0, we_0, cs_0, oe_0} !== '0) begin
      miscompares++;
      $display("FAIL reset_ram_port: got addr=%0h data=%0h we=%0b cs=%0b oe=%0b want all 0",
               addr_0, data_0, we_0, cs_0, oe_0);
    end
    reset = 1'b0;
    model_reset();
    idle(2);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL ready_after_reset: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    make_frame(64, 1'b0);
    send_frame(64, 1'b0);
    @(negedge clk);
    vectors++;
    if ({we_0, cs_0, addr_0, data_0} !== {1'b1, 1'b1, 16'd63, 8'h3F}) begin
      miscompares++;
      $display("FAIL last_beat_port: got we=%0b cs=%0b addr=%0d data=%0h want 1 1 63 3f",
               we_0, cs_0, addr_0, data_0);
    end
    vectors++;
    if (recv_pkt !== 1'b0 || slots_used !== 3'd0) begin
      miscompares++;
      $display("FAIL desc_too_early: got recv=%0b used=%0d want 0 0", recv_pkt, slots_used);
    end
    @(negedge clk);
    vectors++;
    if ({recv_pkt, rx_slot, rx_len, slots_used} !== {1'b1, 2'd0, 12'd64, 3'd1}) begin
      miscompares++;
      $display("FAIL single_desc: got recv=%0b slot=%0d len=%0d used=%0d want 1 0 64 1",
               recv_pkt, rx_slot, rx_len, slots_used);
    end
    idle(2);
    vectors++;
    if (ram_diff() !== 0) begin
      miscompares++; $display("FAIL single_ram: got %0d bad bytes want 0", ram_diff());
    end
  endtask

  task automatic test_fill_and_drop();
    do_reset();
    for (int f = 0; f < 4; f++) begin
      make_frame(100, 1'b1);
      send_frame(100, 1'b0);
    end
    idle(3);
    @(negedge clk);
    vectors++;
    if (slots_used !== 3'd4 || drop_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL fill_four: got used=%0d drop=%0d want 4 0", slots_used, drop_cnt);
    end
    make_frame(100, 1'b1);
    send_frame(100, 1'b0);
    idle(3);
    @(negedge clk);
    vectors++;
    if (drop_cnt !== 16'd1 || slots_used !== 3'd4) begin
      miscompares++;
      $display("FAIL full_drop: got drop=%0d used=%0d want 1 4", drop_cnt, slots_used);
    end
    vectors++;
    if (ram_diff() !== 0) begin
      miscompares++; $display("FAIL full_drop_ram: got %0d bad bytes want 0", ram_diff());
    end
    do_rx_done();
    @(negedge clk);
    vectors++;
    if ({rx_slot, rx_len, slots_used} !== {2'd1, 12'd100, 3'd3}) begin
      miscompares++;
      $display("FAIL release_head: got slot=%0d len=%0d used=%0d want 1 100 3",
               rx_slot, rx_len, slots_used);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    make_frame(SLOT + 1, 1'b1);
    send_frame(SLOT + 1, 1'b0);
    idle(3);
    @(negedge clk);
    vectors++;
    if (drop_cnt !== 16'd1 || recv_pkt !== 1'b0) begin
      miscompares++;
      $display("FAIL oversize_drop: got drop=%0d recv=%0b want 1 0", drop_cnt, recv_pkt);
    end
    make_frame(60, 1'b1);
    send_frame(60, 1'b0);
    idle(3);
    @(negedge clk);
    vectors++;
    if ({recv_pkt, rx_slot, rx_len} !== {1'b1, 2'd0, 12'd60}) begin
      miscompares++;
      $display("FAIL after_oversize: got recv=%0b slot=%0d len=%0d want 1 0 60",
               recv_pkt, rx_slot, rx_len);
    end
    vectors++;
    if (ram_diff() !== 0) begin
      miscompares++; $display("FAIL oversize_ram: got %0d bad bytes want 0", ram_diff());
    end
  endtask

  task automatic test_commit_with_release();
    do_reset();
    for (int f = 0; f < 2; f++) begin
      make_frame(20 + f, 1'b1);
      send_frame(20 + f, 1'b0);
    end
    idle(3);
    make_frame(30, 1'b1);
    send_frame(30, 1'b1);
    @(negedge clk);
    vectors++;
    if ({slots_used, rx_slot, rx_len} !== {3'd2, 2'd1, 12'd21}) begin
      miscompares++;
      $display("FAIL commit_and_release: got used=%0d slot=%0d len=%0d want 2 1 21",
               slots_used, rx_slot, rx_len);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    make_frame(50, 1'b1);
    for (int i = 0; i < 30; i++) exp_ram[i] = frm[i];
    drive_beats(30, 1'b0);
    reset = 1'b1;
    idle(1);
    @(negedge clk);
    vectors++;
    if ({in_ready, recv_pkt, rx_slot, rx_len, slots_used, drop_cnt, addr_0, data_0, we_0, cs_0, oe_0} !== '0) begin
      miscompares++;
      $display("FAIL mid_frame_reset: got rdy=%0b recv=%0b used=%0d drop=%0d we=%0b addr=%0h want all 0",
               in_ready, recv_pkt, slots_used, drop_cnt, we_0, addr_0);
    end
    reset = 1'b0;
    model_reset();
    idle(2);
    make_frame(40, 1'b1);
    send_frame(40, 1'b0);
    idle(3);
    @(negedge clk);
    vectors++;
    if ({recv_pkt, rx_slot, rx_len, slots_used} !== {1'b1, 2'd0, 12'd40, 3'd1}) begin
      miscompares++;
      $display("FAIL after_mid_reset: got recv=%0b slot=%0d len=%0d used=%0d want 1 0 40 1",
               recv_pkt, rx_slot, rx_len, slots_used);
    end
    vectors++;
    if (ram_diff() !== 0) begin
      miscompares++; $display("FAIL mid_reset_ram: got %0d bad bytes want 0", ram_diff());
    end
  endtask

  task automatic test_min_len();
    do_reset();
    make_frame(10, 1'b1);
    send_frame(10, 1'b0);
    idle(3);
    @(negedge clk);
    vectors++;
    if ({recv_pkt, rx_len, drop_cnt} !== {q_slot.size() != 0, 12'(exp_len()), 16'(m_drop)}) begin
      miscompares++;
      $display("FAIL short_frame: got recv=%0b len=%0d drop=%0d want %0b %0d %0d",
               recv_pkt, rx_len, drop_cnt, q_slot.size() != 0, exp_len(), m_drop);
    end
    make_frame(18, 1'b1);
    send_frame(18, 1'b0);
    idle(3);
    @(negedge clk);
    vectors++;
    if ({rx_slot, rx_len, slots_used, drop_cnt} !== {2'(exp_slot()), 12'(exp_len()), 3'(q_slot.size()), 16'(m_drop)}) begin
      miscompares++;
      $display("FAIL min_len_frame: got slot=%0d len=%0d used=%0d drop=%0d want %0d %0d %0d %0d",
               rx_slot, rx_len, slots_used, drop_cnt, exp_slot(), exp_len(), q_slot.size(), m_drop);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 30; it++) begin
      int nrel = $urandom_range(0, 2);
      int nfr  = $urandom_range(1, 3);
      for (int r = 0; r < nrel; r++) do_rx_done();
      for (int f = 0; f < nfr; f++) begin
        int len = ($urandom_range(0, 9) == 0) ? $urandom_range(SLOT - 8, SLOT + 2)
                                              : $urandom_range(1, 150);
        make_frame(len, 1'b1);
        send_frame(len, $urandom_range(0, 4) == 0);
        idle($urandom_range(0, 2));
      end
      idle(3);
      @(negedge clk);
      vectors++;
      if (recv_pkt !== (q_slot.size() != 0)) begin
        miscompares++;
        $display("FAIL rnd_recv it=%0d: got %0b want %0b", it, recv_pkt, q_slot.size() != 0);
      end
      vectors++;
      if (rx_slot !== 2'(exp_slot()) || rx_len !== 12'(exp_len())) begin
        miscompares++;
        $display("FAIL rnd_head it=%0d: got slot=%0d len=%0d want %0d %0d",
                 it, rx_slot, rx_len, exp_slot(), exp_len());
      end
      vectors++;
      if (slots_used !== 3'(q_slot.size())) begin
        miscompares++;
        $display("FAIL rnd_used it=%0d: got %0d want %0d", it, slots_used, q_slot.size());
      end
      vectors++;
      if (drop_cnt !== 16'(m_drop)) begin
        miscompares++;
        $display("FAIL rnd_drop it=%0d: got %0d want %0d", it, drop_cnt, m_drop);
      end
      vectors++;
      if (ram_diff() !== 0) begin
        miscompares++; $display("FAIL rnd_ram it=%0d: got %0d bad bytes want 0", it, ram_diff());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fill_and_drop();
    test_oversize();
    test_commit_with_release();
    test_reset_mid_frame();
    test_min_len();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
